cnn_layer_accel_fas_vec_add_ctrl: RTL and testbench

Sequencer directly upstream of the FAS vector-add stage. It pops convMap, partMap, resdMap, prevMap and conv1x1_dwc FIFOs in lockstep, and drives the stage's `vector_add_*` strobes and `pipe_enable`. It counts depth words and pixels for one job and pulses `process_cmpl`, which also clears the vector-add stage's address counters. It handles control only; FIFO data goes straight to the vector-add stage.

---
 rtl/cnn_layer_accel_FAS_pkg.sv | 34 +++
 rtl/cnn_layer_accel_FAS_wrap_cnt.sv | 30 +++
 rtl/cnn_layer_accel_fas_vec_add_ctrl.sv | 146 ++++++++++++++
 tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_layer_accel_FAS_pkg.sv
// Shared types and constants for the FAS vector-add sequencer.
// The FIFO-requirement helper keeps the mode-to-FIFO mapping in one place.
package cnn_layer_accel_FAS_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fas_vac_state_t;

    localparam int MODE_PM     = 0;
    localparam int MODE_RM     = 1;
    localparam int MODE_RMCONV = 2;
    localparam int MODE_PV     = 3;

    localparam int NUM_FIFO  = 5;
    localparam int FIFO_CONV = 0;
    localparam int FIFO_PART = 1;
    localparam int FIFO_RESD = 2;
    localparam int FIFO_PREV = 3;
    localparam int FIFO_DWC  = 4;

    function automatic logic [NUM_FIFO-1:0] fifo_req(input logic [3:0] m);
        logic [NUM_FIFO-1:0] r;
        r            = '0;
        r[FIFO_CONV] = m[MODE_PM] | m[MODE_RM];
        r[FIFO_PART] = m[MODE_PM];
        r[FIFO_RESD] = m[MODE_RM] | m[MODE_RMCONV];
        r[FIFO_PREV] = m[MODE_PV];
        r[FIFO_DWC]  = m[MODE_RMCONV] | m[MODE_PV];
        return r;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_FAS_wrap_cnt.sv
// Up-counter that wraps to zero after reaching a programmable end value.
// Synchronous clear takes priority over enable.
module cnn_layer_accel_FAS_wrap_cnt #(
    parameter int C_CNT_WTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [C_CNT_WTH-1:0] end_val,
    output logic [C_CNT_WTH-1:0] count,
    output logic                 at_end
);

    logic [C_CNT_WTH-1:0] count_reg;

    assign at_end = (count_reg == end_val);
    assign count  = count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= at_end ? '0 : count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/cnn_layer_accel_fas_vec_add_ctrl.sv
// Lockstep FIFO pop sequencer for the FAS vector-add stage: issues beats,
// counts depth words and pixels, and pulses process_cmpl at job end.
module cnn_layer_accel_fas_vec_add_ctrl
    import cnn_layer_accel_FAS_pkg::*;
#(
    parameter int C_CNT_WTH = 16
) (
    input  logic                 clk_FAS,
    input  logic                 rst,
    input  logic                 FAS_rdy_n,
    input  logic                 start,
    input  logic [3:0]           mode_cfg,
    input  logic [C_CNT_WTH-1:0] krnl1x1_dpth_end_cfg,
    input  logic [C_CNT_WTH-1:0] pix_end_cfg,
    input  logic                 convMap_fifo_empty,
    input  logic                 partMap_fifo_empty,
    input  logic                 resdMap_fifo_empty,
    input  logic                 prevMap_fifo_empty,
    input  logic                 conv1x1_dwc_fifo_empty,
    output logic                 convMap_fifo_rden,
    output logic                 partMap_fifo_rden,
    output logic                 resdMap_fifo_rden,
    output logic                 prevMap_fifo_rden,
    output logic                 conv1x1_dwc_fifo_rden,
    input  logic                 sum_cons_rdy,
    output logic                 vector_add_pm,
    output logic                 vector_add_rm0,
    output logic                 vector_add_rm1,
    output logic                 vector_add_rm_conv,
    output logic                 vector_add_pv,
    output logic                 pipe_enable,
    output logic                 process_cmpl,
    output logic                 busy
);

    fas_vac_state_t       state_reg, state_next;
    logic [3:0]           mode_reg;
    logic [C_CNT_WTH-1:0] dpth_end_reg;
    logic [C_CNT_WTH-1:0] pix_end_reg;

    logic                 start_acc;
    logic                 in_run;
    logic                 final_beat;
    logic                 cnt_clear;
    logic                 pix_enable;
    logic [C_CNT_WTH-1:0] dpth_cnt, pix_cnt;
    logic                 dpth_at_end, pix_at_end;

    logic [NUM_FIFO-1:0]  req_vec, empty_vec, block_vec, rden_vec;

    assign start_acc = (state_reg == ST_IDLE) & start & ~FAS_rdy_n;
    assign in_run    = (state_reg == ST_RUN);

    always_ff @(posedge clk_FAS or posedge rst) begin
        if (rst) begin
            mode_reg     <= '0;
            dpth_end_reg <= '0;
            pix_end_reg  <= '0;
        end else if (start_acc) begin
            mode_reg     <= mode_cfg;
            dpth_end_reg <= krnl1x1_dpth_end_cfg;
            pix_end_reg  <= pix_end_cfg;
        end
    end

    assign req_vec = fifo_req(mode_reg);

    assign empty_vec[FIFO_CONV] = convMap_fifo_empty;
    assign empty_vec[FIFO_PART] = partMap_fifo_empty;
    assign empty_vec[FIFO_RESD] = resdMap_fifo_empty;
    assign empty_vec[FIFO_PREV] = prevMap_fifo_empty;
    assign empty_vec[FIFO_DWC]  = conv1x1_dwc_fifo_empty;

    // Only FIFOs the current mode consumes may stall the beat or be popped.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_FIFO; gi++) begin : g_fifo
            assign block_vec[gi] = req_vec[gi] & empty_vec[gi];
            assign rden_vec[gi]  = req_vec[gi] & pipe_enable;
        end
    endgenerate

    assign pipe_enable = in_run & sum_cons_rdy & ~FAS_rdy_n & ~(|block_vec);

    assign convMap_fifo_rden     = rden_vec[FIFO_CONV];
    assign partMap_fifo_rden     = rden_vec[FIFO_PART];
    assign resdMap_fifo_rden     = rden_vec[FIFO_RESD];
    assign prevMap_fifo_rden     = rden_vec[FIFO_PREV];
    assign conv1x1_dwc_fifo_rden = rden_vec[FIFO_DWC];

    assign vector_add_pm      = in_run & mode_reg[MODE_PM];
    assign vector_add_rm0     = in_run & mode_reg[MODE_RM] & ~mode_reg[MODE_PM];
    assign vector_add_rm1     = in_run & mode_reg[MODE_RM] & mode_reg[MODE_PM];
    assign vector_add_rm_conv = in_run & mode_reg[MODE_RMCONV];
    assign vector_add_pv      = in_run & mode_reg[MODE_PV];

    assign process_cmpl = (state_reg == ST_DONE);
    assign busy         = (state_reg != ST_IDLE);

    // Pixel counter holds at its end value; the next start clears it.
    assign cnt_clear  = start_acc | FAS_rdy_n;
    assign pix_enable = pipe_enable & dpth_at_end & ~pix_at_end;
    assign final_beat = pipe_enable & (dpth_cnt == dpth_end_reg) & (pix_cnt == pix_end_reg);

    cnn_layer_accel_FAS_wrap_cnt #(.C_CNT_WTH(C_CNT_WTH)) u_dpth_cnt (
        .clk     (clk_FAS),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (pipe_enable),
        .end_val (dpth_end_reg),
        .count   (dpth_cnt),
        .at_end  (dpth_at_end)
    );

    cnn_layer_accel_FAS_wrap_cnt #(.C_CNT_WTH(C_CNT_WTH)) u_pix_cnt (
        .clk     (clk_FAS),
        .rst     (rst),
        .clear   (cnt_clear),
        .enable  (pix_enable),
        .end_val (pix_end_reg),
        .count   (pix_cnt),
        .at_end  (pix_at_end)
    );

    always_ff @(posedge clk_FAS or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_acc) state_next = (mode_cfg == 4'd0) ? ST_DONE : ST_RUN;
            ST_RUN:  if (final_beat) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (FAS_rdy_n) begin
            state_next = ST_IDLE;
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_fas_vec_add_ctrl.sv
// Directed and randomized jobs checked against a beat-counting job model.
module tb_cnn_layer_accel_fas_vec_add_ctrl;

    localparam int W      = 16;
    localparam int BUDGET = 3000;

    logic         clk_FAS = 1'b0;
    logic         rst;
    logic         FAS_rdy_n;
    logic         start;
    logic [3:0]   mode_cfg;
    logic [W-1:0] dpth_end;
    logic [W-1:0] pix_end;
    logic         conv_e, part_e, resd_e, prev_e, dwc_e;
    logic         conv_r, part_r, resd_r, prev_r, dwc_r;
    logic         sum_cons_rdy;
    logic         va_pm, va_rm0, va_rm1, va_rmc, va_pv;
    logic         pipe_enable, process_cmpl, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_FAS = ~clk_FAS;

    cnn_layer_accel_fas_vec_add_ctrl #(.C_CNT_WTH(W)) dut (
        .clk_FAS                (clk_FAS),
        .rst                    (rst),
        .FAS_rdy_n              (FAS_rdy_n),
        .start                  (start),
        .mode_cfg               (mode_cfg),
        .krnl1x1_dpth_end_cfg   (dpth_end),
        .pix_end_cfg            (pix_end),
        .convMap_fifo_empty     (conv_e),
        .partMap_fifo_empty     (part_e),
        .resdMap_fifo_empty     (resd_e),
        .prevMap_fifo_empty     (prev_e),
        .conv1x1_dwc_fifo_empty (dwc_e),
        .convMap_fifo_rden      (conv_r),
        .partMap_fifo_rden      (part_r),
        .resdMap_fifo_rden      (resd_r),
        .prevMap_fifo_rden      (prev_r),
        .conv1x1_dwc_fifo_rden  (dwc_r),
        .sum_cons_rdy           (sum_cons_rdy),
        .vector_add_pm          (va_pm),
        .vector_add_rm0         (va_rm0),
        .vector_add_rm1         (va_rm1),
        .vector_add_rm_conv     (va_rmc),
        .vector_add_pv          (va_pv),
        .pipe_enable            (pipe_enable),
        .process_cmpl           (process_cmpl),
        .busy                   (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit order {dwc, prev, resd, part, conv}: which FIFOs a mode consumes.
    function automatic logic [4:0] model_req(input logic [3:0] m);
        logic pm, rm, rmc, pv;
        {pv, rmc, rm, pm} = m;
        return {rmc | pv, pv, rm | rmc, pm, pm | rm};
    endfunction

    // Bit order {pv, rm_conv, rm1, rm0, pm}.
    function automatic logic [4:0] model_strb(input logic [3:0] m);
        logic pm, rm, rmc, pv;
        {pv, rmc, rm, pm} = m;
        return {pv, rmc, rm & pm, rm & ~pm, pm};
    endfunction

    function automatic logic [4:0] rden_obs();
        return {dwc_r, prev_r, resd_r, part_r, conv_r};
    endfunction

    function automatic logic [4:0] strb_obs();
        return {va_pv, va_rmc, va_rm1, va_rm0, va_pm};
    endfunction

    task automatic drive_empty(input logic [4:0] e);
        {dwc_e, prev_e, resd_e, part_e, conv_e} = e;
    endtask

    task automatic next_cycle();
        @(posedge clk_FAS);
        #1;
    endtask

    // pat: 0 = only unused FIFOs empty, 1 = resd empty on odd cycles,
    //      2 = random empties and random sum_cons_rdy, 3 = partMap always empty.
    task automatic run_job(input logic [3:0] m, input int dend, input int pend,
                           input int pat, input int abort_after,
                           output int beats, output int cmpl_cyc);
        logic [4:0] req;
        logic [4:0] e;
        logic       cons, ab, exp_pe;
        int         remaining, cyc;
        bit         in_run;

        req       = model_req(m);
        remaining = (dend + 1) * (pend + 1);
        beats     = 0;
        cmpl_cyc  = -1;

        mode_cfg     = m;
        dpth_end     = W'(dend);
        pix_end      = W'(pend);
        start        = 1'b1;
        sum_cons_rdy = 1'b1;
        drive_empty(5'd0);
        #3;
        chk("start_cycle_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        start  = 1'b0;
        cyc    = 1;
        in_run = (m != 4'd0);

        while (cyc < BUDGET) begin
            if (in_run) begin
                case (pat)
                    0:       e = ~req;
                    1:       e = (cyc % 2 == 1) ? 5'b00100 : 5'b00000;
                    2:       e = 5'($urandom) & 5'($urandom);
                    default: e = 5'b00010;
                endcase
                cons         = (pat == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
                ab           = (abort_after >= 0) && (beats == abort_after);
                drive_empty(e);
                sum_cons_rdy = cons;
                FAS_rdy_n    = ab;
                exp_pe       = cons & ~ab & ((req & e) == 5'd0);
                #3;
                chk("run_pipe_enable", {31'd0, pipe_enable}, {31'd0, exp_pe});
                chk("run_rden", {27'd0, rden_obs()}, {27'd0, exp_pe ? req : 5'd0});
                chk("run_strobes", {27'd0, strb_obs()}, {27'd0, model_strb(m)});
                chk("run_busy", {31'd0, busy}, 32'd1);
                chk("run_cmpl", {31'd0, process_cmpl}, 32'd0);
                if (ab) begin
                    next_cycle();
                    FAS_rdy_n = 1'b0;
                    #3;
                    chk("abort_busy", {31'd0, busy}, 32'd0);
                    chk("abort_cmpl", {31'd0, process_cmpl}, 32'd0);
                    chk("abort_strobes", {27'd0, strb_obs()}, 32'd0);
                    break;
                end
                if (exp_pe) begin
                    beats++;
                    remaining--;
                    if (remaining == 0) in_run = 1'b0;
                end
                next_cycle();
                cyc++;
            end else begin
                // Completion cycle; a start here must be ignored.
                drive_empty(5'($urandom));
                sum_cons_rdy = 1'b1;
                start        = 1'b1;
                mode_cfg     = 4'($urandom_range(1, 15));
                #3;
                chk("done_cmpl", {31'd0, process_cmpl}, 32'd1);
                chk("done_busy", {31'd0, busy}, 32'd1);
                chk("done_pipe_enable", {31'd0, pipe_enable}, 32'd0);
                chk("done_rden", {27'd0, rden_obs()}, 32'd0);
                cmpl_cyc = cyc;
                next_cycle();
                start = 1'b0;
                cyc++;
                #3;
                chk("after_done_busy", {31'd0, busy}, 32'd0);
                chk("after_done_cmpl", {31'd0, process_cmpl}, 32'd0);
                break;
            end
        end
        chk("job_cycle_budget", {31'd0, cyc >= BUDGET}, 32'd0);
        $display("job mode=%0h dpth_end=%0d pix_end=%0d pat=%0d beats=%0d cmpl_cycle=%0d",
                 m, dend, pend, pat, beats, cmpl_cyc);
        next_cycle();
    endtask

    initial begin
        int         beats, cmpl_cyc, dend, pend;
        logic [3:0] m;

        rst          = 1'b1;
        FAS_rdy_n    = 1'b0;
        start        = 1'b0;
        mode_cfg     = 4'd0;
        dpth_end     = '0;
        pix_end      = '0;
        sum_cons_rdy = 1'b1;
        drive_empty(5'd0);
        #12;
        chk("reset_pipe_enable", {31'd0, pipe_enable}, 32'd0);
        chk("reset_rden", {27'd0, rden_obs()}, 32'd0);
        chk("reset_strobes", {27'd0, strb_obs()}, 32'd0);
        chk("reset_busy_cmpl", {30'd0, busy, process_cmpl}, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_job(4'b0001, 3, 1, 0, -1, beats, cmpl_cyc);
        chk("pm_beats", beats, 32'd8);
        chk("pm_cmpl_cycle", cmpl_cyc, 32'd9);

        run_job(4'b0011, 2, 2, 1, -1, beats, cmpl_cyc);
        chk("pmrm_beats", beats, 32'd9);

        run_job(4'b1000, 1, 3, 3, -1, beats, cmpl_cyc);
        chk("pv_beats", beats, 32'd8);
        chk("pv_cmpl_cycle", cmpl_cyc, 32'd9);

        run_job(4'b0100, 3, 2, 0, 5, beats, cmpl_cyc);
        chk("abort_beats", beats, 32'd5);
        chk("abort_no_cmpl", cmpl_cyc, 32'hFFFF_FFFF);
        run_job(4'b0100, 3, 2, 0, -1, beats, cmpl_cyc);
        chk("restart_beats", beats, 32'd12);
        chk("restart_cmpl_cycle", cmpl_cyc, 32'd13);

        run_job(4'b0000, 2, 2, 0, -1, beats, cmpl_cyc);
        chk("mode0_beats", beats, 32'd0);
        chk("mode0_cmpl_cycle", cmpl_cyc, 32'd1);

        for (int j = 0; j < 8; j++) begin
            m    = 4'($urandom_range(1, 15));
            dend = $urandom_range(0, 3);
            pend = $urandom_range(0, 3);
            run_job(m, dend, pend, 2, -1, beats, cmpl_cyc);
            chk("rand_beats", beats, (dend + 1) * (pend + 1));
        end

        // Asynchronous reset in the middle of a running job.
        mode_cfg     = 4'b0001;
        dpth_end     = W'(5);
        pix_end      = W'(5);
        sum_cons_rdy = 1'b1;
        drive_empty(5'd0);
        start        = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        #2;
        chk("pre_reset_pipe_enable", {31'd0, pipe_enable}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_pipe_enable", {31'd0, pipe_enable}, 32'd0);
        chk("async_rst_rden", {27'd0, rden_obs()}, 32'd0);
        chk("async_rst_strobes", {27'd0, strb_obs()}, 32'd0);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        #3;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_pipe_enable", {31'd0, pipe_enable}, 32'd0);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
